// File: rtl/ntt_addr_unperm.sv
// Address generator that sweeps j = 0..31 and emits the inverse-permuted
// coefficient address for the latched NTT stage, with valid/ready handshake.
module ntt_addr_unperm #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        stage,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_last,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] J_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] J_LAST = {ADDR_W{1'b1}};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_j;
  logic [ADDR_W-1:0] w_j_nxt;
  logic [1:0]        r_stage;
  logic [1:0]        w_stage_nxt;
  logic              w_run;
  logic [ADDR_W-1:0] w_addr_s0;
  logic [ADDR_W-1:0] w_addr_s1;
  logic [ADDR_W-1:0] w_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_j     <= '0;
      r_stage <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_j     <= w_j_nxt;
      r_stage <= w_stage_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_j_nxt     = r_j;
    w_stage_nxt = r_stage;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_j_nxt     = '0;
          w_stage_nxt = stage;
        end
      end
      S_RUN: begin
        if (out_ready) begin
          if (r_j == J_LAST) begin
            w_state_nxt = S_DONE;
          end else begin
            w_j_nxt = r_j + J_ONE;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_j_nxt     = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_j_nxt     = '0;
      end
    endcase
  end

  // Inverse permutations are pure bit rotations of j: stage 0 rotates the whole
  // index, stage 1 rotates only the low three bits within each group of eight.
  assign w_addr_s0 = {r_j[2:0], r_j[4:3]};
  assign w_addr_s1 = {r_j[4:3], r_j[0], r_j[2:1]};

  always_comb begin
    w_addr = r_j;
    case (r_stage)
      2'd0:    w_addr = w_addr_s0;
      2'd1:    w_addr = w_addr_s1;
      default: w_addr = r_j;
    endcase
  end

  assign w_run     = (r_state == S_RUN);
  assign out_valid = w_run;
  assign out_idx   = w_run ? r_j : '0;
  assign out_addr  = w_run ? w_addr : '0;
  assign out_last  = w_run && (r_j == J_LAST);
  assign done      = (r_state == S_DONE);
  assign busy      = w_run || (r_state == S_DONE);

endmodule

// File: doc/ntt_addr_unperm.md
NTT_ADDR_UNPERM -- requirements
Module: ntt_addr_unperm

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, meaning the coefficient address width (32 entries per stage); only 5 is supported.
REQ-002 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, request one 32-address sweep.
REQ-005 SHALL have port stage, input, 2, permutation stage, sampled with an accepted start.
REQ-006 SHALL have port busy, output, 1, high in RUN and DONE states.
REQ-007 SHALL have port out_valid, output, 1, out_addr/out_idx/out_last are valid.
REQ-008 SHALL have port out_ready, input, 1, consumer accepts the current beat.
REQ-009 SHALL have port out_addr, output, ADDR_W, inverse-permuted address.
REQ-010 SHALL have port out_idx, output, ADDR_W, sequence index j of the current beat.
REQ-011 SHALL have port out_last, output, 1, high on the beat with out_idx==31.
REQ-012 SHALL have port done, output, 1, one-cycle pulse after the last beat transfers.

Function
REQ-013 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-014 SHALL accept start only in IDLE, then latch stage, clear the counter j to 0 and enter RUN on the next edge.
REQ-015 SHALL ignore start in RUN and DONE; the latched stage SHALL NOT change mid-sweep.
REQ-016 SHALL drive out_valid high for every RUN cycle, with the first beat in the cycle after start was sampled.
REQ-017 SHALL count a transfer only in a cycle where out_valid and out_ready are both high; j SHALL increment by 1 per transfer.
REQ-018 SHALL hold out_addr, out_idx and out_last stable while out_valid=1 and out_ready=0.
REQ-019 SHALL, for stage 0, set out_addr = (j mod 8)*4 + floor(j/8), the inverse of the forward map i -> (i mod 4)*8 + floor(i/4).
REQ-020 SHALL, for stage 1, set out_addr = 8*floor(j/8) + (j mod 2)*4 + floor((j mod 8)/2), the inverse of the forward map 8g+r -> 8g+(r mod 4)*2+floor(r/4).
REQ-021 SHALL, for stages 2 and 3, set out_addr = j (identity).
REQ-022 SHALL compute out_addr with pure bit rewiring of j, with no arithmetic carry and no ROM.
REQ-023 SHALL, on a transfer with j==31, enter DONE with no wrap to j=0 while in RUN.
REQ-024 SHALL, in DONE, hold out_valid=0, raise done for exactly one cycle, then return to IDLE.
REQ-025 SHALL accept a start sampled in the IDLE cycle right after DONE, giving sweeps with a minimum gap of 2 cycles.
REQ-026 SHALL hold out_valid, out_last and done at 0, and out_addr/out_idx at 0, outside RUN and DONE.

Reset
REQ-027 SHALL, on rst_n low at any time (including mid-sweep), force IDLE, j=0, stage=0 and all outputs to 0 immediately, without waiting for clk.
REQ-028 SHALL wait for a new start after rst_n deasserts; no partial sweep SHALL resume.

Verification
REQ-029 SHALL cover: stage=0, ready held 1 -> out_addr sequence 0,4,8,12,16,20,24,28,1,5,...,31; out_last and out_idx=31 on beat 32; done one cycle later.
REQ-030 SHALL cover: stage=1, ready held 1 -> out_addr sequence 0,4,1,5,2,6,3,7, then the same pattern +8, +16 and +24; stages 2 and 3 -> 0..31 in order.
REQ-031 SHALL cover: random out_ready stalls -> outputs stable during stalls, exactly 32 transfers, and the forward map applied to out_addr equals out_idx for every beat.
REQ-032 SHALL cover: start pulsed during RUN with stage changed -> ignored, and the sweep completes with the original stage.
REQ-033 SHALL cover: rst_n asserted at j=13 -> outputs 0 asynchronously, and a new start yields a full sweep from j=0.
REQ-034 SHALL cover: start held high continuously -> back-to-back sweeps with first beats 34 cycles apart when out_ready=1.
